// File: rtl/cpu_dump_pkg.sv
// Shared types and constants for the CPU state dumper.
package cpu_dump_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StQuiesce = 3'd1,
        StReg     = 3'd2,
        StMem     = 3'd3,
        StCsum    = 3'd4,
        StDrain   = 3'd5
    } dump_state_e;

    localparam logic       TAG_SPACE_REG = 1'b0;
    localparam logic       TAG_SPACE_MEM = 1'b1;
    localparam logic [7:0] TAG_CSUM      = 8'hFF;

    // Tag layout: [7] address space, [6:0] word index within that space.
    function automatic logic [7:0] make_tag(input logic space, input logic [6:0] idx);
        return {space, idx};
    endfunction

endpackage

// File: rtl/dump_out_stage.sv
// Single-entry valid/ready holding register for dump beats.
module dump_out_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cap_i,
    input  logic [31:0] data_i,
    input  logic [7:0]  tag_i,
    input  logic        last_i,
    input  logic        ready_i,
    output logic        load_o,
    output logic        valid_o,
    output logic [31:0] data_o,
    output logic [7:0]  tag_o,
    output logic        last_o
);

    logic        r_valid;
    logic [31:0] r_data;
    logic [7:0]  r_tag;
    logic        r_last;

    // The slot can take a new beat when empty or when its beat leaves this cycle.
    assign load_o = !r_valid || ready_i;

    // Capture a new beat on load, otherwise hold everything stable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_tag   <= '0;
            r_last  <= 1'b0;
        end else if (load_o) begin
            r_valid <= cap_i;
            r_last  <= cap_i & last_i;
            if (cap_i) begin
                r_data <= data_i;
                r_tag  <= tag_i;
            end
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign tag_o   = r_tag;
    assign last_o  = r_last;

endmodule

// File: rtl/cpu_state_dumper.sv
// Stalls the CPU and streams every register-file entry, then every data-memory word.
// Optional checksum beat: define DUMP_CHECKSUM_EN.
module cpu_state_dumper
    import cpu_dump_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned DM_WORDS = 32,
    parameter int unsigned DM_AW    = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             dump_req_i,
    output logic             cpu_stall_o,
    output logic             busy_o,
    output logic [4:0]       rf_addr_o,
    input  logic [31:0]      rf_data_i,
    output logic [DM_AW-1:0] dm_addr_o,
    input  logic [31:0]      dm_data_i,
    output logic             dump_valid_o,
    input  logic             dump_ready_i,
    output logic [31:0]      dump_data_o,
    output logic [7:0]       dump_tag_o,
    output logic             dump_last_o
);

    localparam logic [6:0] RegLast = 7'(NUM_REGS - 1);
    localparam logic [6:0] MemLast = 7'(DM_WORDS - 1);

    dump_state_e r_state;
    logic [6:0]  r_idx;
    logic        r_busy;
`ifdef DUMP_CHECKSUM_EN
    logic [31:0] r_sum;
`endif

    logic        w_load;
    logic        w_cap;
    logic [31:0] w_cap_data;
    logic [7:0]  w_cap_tag;
    logic        w_cap_last;

    // Select the beat the current state would emit.
    always_comb begin
        w_cap      = 1'b0;
        w_cap_data = '0;
        w_cap_tag  = '0;
        w_cap_last = 1'b0;
        case (r_state)
            StReg: begin
                w_cap      = 1'b1;
                w_cap_data = rf_data_i;
                w_cap_tag  = make_tag(TAG_SPACE_REG, r_idx);
            end
            StMem: begin
                w_cap      = 1'b1;
                w_cap_data = dm_data_i;
                w_cap_tag  = make_tag(TAG_SPACE_MEM, r_idx);
`ifndef DUMP_CHECKSUM_EN
                w_cap_last = (r_idx == MemLast);
`endif
            end
`ifdef DUMP_CHECKSUM_EN
            StCsum: begin
                w_cap      = 1'b1;
                w_cap_data = r_sum;
                w_cap_tag  = TAG_CSUM;
                w_cap_last = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Sequencer: index walk through both spaces; state advances on the last index.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_busy  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            r_sum   <= '0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (dump_req_i) begin
                        r_state <= StQuiesce;
                        r_busy  <= 1'b1;
                        r_idx   <= '0;
`ifdef DUMP_CHECKSUM_EN
                        r_sum   <= '0;
`endif
                    end
                end
                // One idle cycle lets an in-flight CPU write retire before reading.
                StQuiesce: r_state <= StReg;
                StReg: begin
                    if (w_load) begin
`ifdef DUMP_CHECKSUM_EN
                        r_sum <= r_sum + w_cap_data;
`endif
                        if (r_idx == RegLast) begin
                            r_idx   <= '0;
                            r_state <= StMem;
                        end else begin
                            r_idx <= r_idx + 7'd1;
                        end
                    end
                end
                StMem: begin
                    if (w_load) begin
`ifdef DUMP_CHECKSUM_EN
                        r_sum <= r_sum + w_cap_data;
`endif
                        if (r_idx == MemLast) begin
`ifdef DUMP_CHECKSUM_EN
                            r_state <= StCsum;
`else
                            r_state <= StDrain;
`endif
                        end else begin
                            r_idx <= r_idx + 7'd1;
                        end
                    end
                end
                StCsum: begin
                    if (w_load) r_state <= StDrain;
                end
                StDrain: begin
                    if (dump_valid_o && dump_ready_i) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    dump_out_stage u_out (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .cap_i   (w_cap),
        .data_i  (w_cap_data),
        .tag_i   (w_cap_tag),
        .last_i  (w_cap_last),
        .ready_i (dump_ready_i),
        .load_o  (w_load),
        .valid_o (dump_valid_o),
        .data_o  (dump_data_o),
        .tag_o   (dump_tag_o),
        .last_o  (dump_last_o)
    );

    assign busy_o      = r_busy;
    assign cpu_stall_o = r_busy;
    assign rf_addr_o   = r_idx[4:0];
    assign dm_addr_o   = r_idx[DM_AW-1:0];

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Bench for cpu_state_dumper: full-size and 1/1 instances against a beat-list model.
module tb_cpu_state_dumper;

`ifdef DUMP_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic [31:0] rf [32];
  logic [31:0] mem [32];

  // Full-size instance
  logic        req = 1'b0, ready = 1'b0;
  logic        stall, busy, valid, last;
  logic [4:0]  rf_addr, dm_addr;
  logic [31:0] rf_data, dm_data, data;
  logic [7:0]  tag;
  assign rf_data = rf[rf_addr];
  assign dm_data = mem[dm_addr];

  cpu_state_dumper #(.NUM_REGS(32), .DM_WORDS(32), .DM_AW(5)) u_dut (
    .clk_i(clk), .rst_i(rst), .dump_req_i(req), .cpu_stall_o(stall), .busy_o(busy),
    .rf_addr_o(rf_addr), .rf_data_i(rf_data), .dm_addr_o(dm_addr), .dm_data_i(dm_data),
    .dump_valid_o(valid), .dump_ready_i(ready), .dump_data_o(data), .dump_tag_o(tag),
    .dump_last_o(last)
  );

  // Corner instance: one register, one memory word
  logic        req_b = 1'b0, ready_b = 1'b0;
  logic        stall_b, busy_b, valid_b, last_b;
  logic [4:0]  rf_addr_b;
  logic [0:0]  dm_addr_b;
  logic [31:0] rf_data_b, dm_data_b, data_b;
  logic [7:0]  tag_b;
  assign rf_data_b = rf[rf_addr_b];
  assign dm_data_b = mem[dm_addr_b];

  cpu_state_dumper #(.NUM_REGS(1), .DM_WORDS(1), .DM_AW(1)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .dump_req_i(req_b), .cpu_stall_o(stall_b), .busy_o(busy_b),
    .rf_addr_o(rf_addr_b), .rf_data_i(rf_data_b), .dm_addr_o(dm_addr_b),
    .dm_data_i(dm_data_b), .dump_valid_o(valid_b), .dump_ready_i(ready_b),
    .dump_data_o(data_b), .dump_tag_o(tag_b), .dump_last_o(last_b)
  );

  // Expected beat list
  logic [31:0] q_data [$];
  logic [7:0]  q_tag  [$];
  logic        q_last [$];

  task automatic build_exp(input int nr, input int dw);
    logic [31:0] sum;
    q_data.delete(); q_tag.delete(); q_last.delete();
    sum = 0;
    for (int i = 0; i < nr; i++) begin
      q_data.push_back(rf[i]); q_tag.push_back(8'(i)); q_last.push_back(1'b0);
      sum += rf[i];
    end
    for (int j = 0; j < dw; j++) begin
      q_data.push_back(mem[j]); q_tag.push_back(8'(8'h80 + j));
      q_last.push_back((CSUM == 0) && (j == dw - 1));
      sum += mem[j];
    end
    if (CSUM != 0) begin
      q_data.push_back(sum); q_tag.push_back(8'hFF); q_last.push_back(1'b1);
    end
  endtask

  task automatic preload(input bit rnd);
    for (int i = 0; i < 32; i++) begin
      rf[i]  = rnd ? $urandom : 32'(i * 3);
      mem[i] = rnd ? $urandom : 32'(100 + i);
    end
  endtask

  // mode 0: ready high; 1: toggling ready with a 5-cycle hold on beat 31;
  // 2: random ready; 3: ready high plus a req pulse at beat 10.
  // rst_tag >= 0 resets the DUT while that tag is presented.
  task automatic run_dump(input int mode, input int rst_tag);
    int          beats, first_valid, last_cycle, hold, nbeats;
    bit          done, pv, pr, hold_used;
    logic [31:0] pd;
    logic [7:0]  pt;
    logic        pl;
    build_exp(32, 32);
    nbeats = q_data.size();
    beats = 0; first_valid = -1; last_cycle = -1; hold = 0;
    done = 0; pv = 0; pr = 0; hold_used = 0; pd = 0; pt = 0; pl = 0;
    @(negedge clk);
    req = 1'b1;
    ready = (mode != 1);
    for (int c = 1; c < 3000 && !done; c++) begin
      @(negedge clk);
      req = (mode == 3) && (beats == 10);
      chk("stall_during_dump", stall, 1'b1);
      chk("busy_during_dump", busy, 1'b1);
      if (pv && !pr) begin
        chk("hold_valid", valid, 1'b1);
        chk("hold_data", data, pd);
        chk("hold_tag", tag, pt);
        chk("hold_last", last, pl);
      end
      if (first_valid < 0 && valid) first_valid = c;
      case (mode)
        1: begin
          if (hold > 0) begin
            ready = 1'b0; hold--;
          end else if (valid && beats == 31 && !hold_used) begin
            ready = 1'b0; hold = 4; hold_used = 1;
          end else begin
            ready = ~ready;
          end
        end
        2: ready = 1'($urandom_range(0, 1));
        default: ready = 1'b1;
      endcase
      if (rst_tag >= 0 && valid && tag == 8'(rst_tag)) begin
        rst = 1'b1; ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", valid, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_busy", busy, 1'b0);
        return;
      end
      if (valid && ready) begin
        if (q_data.size() == 0) begin
          chk("extra_beat", valid, 1'b0);
          done = 1;
        end else begin
          chk("beat_tag", tag, q_tag[0]);
          chk("beat_data", data, q_data[0]);
          chk("beat_last", last, q_last[0]);
          void'(q_data.pop_front()); void'(q_tag.pop_front()); void'(q_last.pop_front());
          beats++;
          if (q_data.size() == 0) begin done = 1; last_cycle = c; end
        end
      end
      pv = valid; pr = ready; pd = data; pt = tag; pl = last;
    end
    chk("dump_completed", done, 1'b1);
    chk("beat_count", beats, nbeats);
    @(negedge clk);
    ready = 1'b0;
    chk("idle_valid", valid, 1'b0);
    chk("idle_stall", stall, 1'b0);
    chk("idle_busy", busy, 1'b0);
    if (mode == 0) begin
      chk("first_valid_cycle", first_valid, 3);
      chk("last_accept_cycle", last_cycle, 3 + nbeats - 1);
    end
  endtask

  initial begin
    int nb;
    preload(0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", valid, 1'b0);
    chk("reset_stall", stall, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_data", data, 32'h0);
    chk("reset_tag", tag, 8'h0);
    chk("reset_last", last, 1'b0);
    chk("reset_rf_addr", rf_addr, 5'h0);
    chk("reset_dm_addr", dm_addr, 5'h0);
    chk("reset_b_valid", valid_b, 1'b0);
    chk("reset_b_busy", busy_b, 1'b0);

    run_dump(0, -1);
    run_dump(1, -1);
    run_dump(0, 8'h85);
    run_dump(0, -1);
    run_dump(3, -1);
    preload(1);
    run_dump(2, -1);
    run_dump(2, -1);

    // 1/1 corner instance
    preload(1);
    build_exp(1, 1);
    nb = 0;
    @(negedge clk);
    req_b = 1'b1; ready_b = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      req_b = 1'b0;
      if (valid_b) begin
        if (q_data.size() == 0) begin
          chk("b_extra_beat", valid_b, 1'b0);
        end else begin
          chk("b_beat_tag", tag_b, q_tag[0]);
          chk("b_beat_data", data_b, q_data[0]);
          chk("b_beat_last", last_b, q_last[0]);
          void'(q_data.pop_front()); void'(q_tag.pop_front()); void'(q_last.pop_front());
        end
        nb++;
      end
    end
    chk("b_beat_count", nb, 2 + CSUM);
    chk("b_idle_busy", busy_b, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_state_dumper.md
Name: cpu_state_dumper

Overview:
- Hardware counterpart to bench-side state inspection. On request, it stalls Simple_Single_CPU and reads every register-file entry, then every data-memory word.
- Emits each word as one beat on a valid/ready stream with an address tag.
- Sits beside the CPU top level. It uses a dedicated combinational read port on the register bank and one on data memory, and drives the CPU stall input.

Parameters:
NUM_REGS, 32, register-file entries dumped (1..32)
DM_WORDS, 32, data-memory words dumped (1..128)
DM_AW, 5, data-memory word-address width (2^DM_AW >= DM_WORDS)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous active-high reset
dump_req_i  in  1  start request, sampled only in IDLE
cpu_stall_o  out  1  holds CPU PC and all CPU writes while high
busy_o  out  1  high in every state except IDLE
rf_addr_o  out  5  register-file read address
rf_data_i  in  32  register-file read data, combinational from rf_addr_o
dm_addr_o  out  DM_AW  data-memory word read address
dm_data_i  in  32  data-memory read data, combinational from dm_addr_o
dump_valid_o  out  1  output beat valid
dump_ready_i  in  1  sink ready
dump_data_o  out  32  beat payload
dump_tag_o  out  8  [7] space (0 = reg, 1 = mem), [6:0] index; 8'hFF = checksum beat
dump_last_o  out  1  high on final beat

Behaviour:
- Reset: all state returns to IDLE in the same cycle, from any state, including mid-dump. The next beat is not emitted.
  - Reset values: cpu_stall_o=0, busy_o=0, dump_valid_o=0, dump_data_o=0, dump_tag_o=0, dump_last_o=0, rf_addr_o=0, dm_addr_o=0, idx=0.
- States:
  - IDLE -> QUIESCE when dump_req_i=1. Stall asserts from the next edge.
  - QUIESCE: one cycle, so any CPU write in flight retires. -> REG.
  - REG: rf_addr_o = idx.
  - MEM: dm_addr_o = idx.
  - DRAIN: waits for the final beat to be accepted. -> IDLE.
- Output register: one stage. "Load" means (!dump_valid_o || dump_ready_i).
  - In REG or MEM with load true: capture the read data and tag, set valid, increment idx.
  - REG at idx = NUM_REGS-1: load also clears idx and moves to MEM.
  - MEM at idx = DM_WORDS-1: load also moves to DRAIN, or to CSUM when checksum is compiled in.
- Throughput: one beat per cycle when ready is held high. The first beat is valid 2 cycles after the req edge.
- Without backpressure, total dump takes NUM_REGS+DM_WORDS beats, plus 1 with checksum.
- Handshake: while valid=1 and ready=0, data, tag and last hold stable. Valid never drops without acceptance.
- dump_last_o=1 only on the final beat.
- cpu_stall_o = busy_o. It deasserts in the cycle after the final beat is accepted.
- dump_req_i while busy is ignored; no queuing. A req held high after DONE starts a new dump from IDLE.
- Register 0 is dumped as read; no forced zero.
- Index counter is 7 bits and never wraps past the last index; the state changes first.

Optional Feature:
DUMP_CHECKSUM_EN
- Defined:
  - A 32-bit sum (mod 2^32) accumulates every accepted data beat. It clears on entering QUIESCE.
  - State CSUM emits one extra beat: tag 8'hFF, data = sum, last=1. The last memory beat then has last=0.
- Undefined: no accumulator and no CSUM state. The last memory beat carries last=1.

Decomposition:
- Package cpu_dump_pkg:
  - state enum (IDLE, QUIESCE, REG, MEM, CSUM, DRAIN)
  - TAG_SPACE_REG/TAG_SPACE_MEM constants
  - TAG_CSUM = 8'hFF
- One sub-module, dump_out_stage: the valid/ready holding register with the load condition. The FSM and counters stay in the top.

Test Plan:
- Register preload: REGISTER_BANK[i]=i*3, memory[j]=100+j. Pulse req, ready=1.
  - Expect 64 consecutive beats: tags 0x00..0x1F then 0x80..0x9F, data matching.
  - last only on tag 0x9F; stall high from req+1 until the cycle after the last beat.
- Backpressure: toggle ready every cycle; hold ready=0 for 5 cycles on beat 31.
  - Data, tag and last stable while stalled.
  - No beat duplicated or skipped; REG->MEM transition correct.
- Reset mid-dump: assert rst_i while beat tag 0x85 is valid.
  - Next cycle: valid=0, stall=0, busy=0.
  - A fresh req restarts at tag 0x00.
- Req while busy: pulse req at beat 10. Expect no effect; exactly 64 beats, then IDLE.
- DUMP_CHECKSUM_EN with the preload above: 65th beat has tag 0xFF and data = sum(i*3, i=0..31) + sum(100+j, j=0..31) = 1488 + 3696 = 5184, with last=1. Beat 0x9F has last=0.
- Parameter corner NUM_REGS=1, DM_WORDS=1: exactly 2 beats (tags 0x00, 0x80); last on the second.
